// File: rtl/alu_seq_if.sv
// Request/result handshake bundle for alu_seq: operands and op select in, result and condition codes out.
interface alu_seq_if #(
  parameter int unsigned WIDTH = 32
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] aluA;
  logic [WIDTH-1:0] aluB;
  logic [3:0]       alufun;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] valE;
  logic [2:0]       cc;
  logic             err;

  modport master (
    output in_valid, aluA, aluB, alufun, out_ready,
    input  in_ready, out_valid, valE, cc, err
  );

  modport slave (
    input  in_valid, aluA, aluB, alufun, out_ready,
    output in_ready, out_valid, valE, cc, err
  );
endinterface

// File: rtl/alu_seq.sv
// Handshaked execute-stage ALU producing valE and {ZF,SF,OF}; results held until accepted.
// Define ALU_MUL_EN to build in the iterative shift-add multiplier (alufun 8, WIDTH+1 cycle latency).
module alu_seq #(
  parameter int unsigned WIDTH = 32
) (
  input  logic    clk,
  input  logic    rst_n,
  alu_seq_if.slave bus
);
  localparam int unsigned SHW = $clog2(WIDTH);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
`ifdef ALU_MUL_EN
    BUSY = 2'd1,
`endif
    DONE = 2'd2
  } state_t;

  state_t           state, stateNext;
  logic [WIDTH-1:0] valEReg, valENext;
  logic [2:0]       ccReg, ccNext;
  logic             errReg, errNext;

  logic [WIDTH-1:0] res;
  logic             ovf;
  logic             unsup;
  logic             isMul;
  logic [SHW-1:0]   sh;

`ifdef ALU_MUL_EN
  localparam int unsigned CNTW = SHW + 1;
  logic [CNTW-1:0]  cnt, cntNext;
  logic [WIDTH-1:0] acc, accNext;
  logic [WIDTH-1:0] mcand, mcandNext;
  logic [WIDTH-1:0] mplier, mplierNext;
`endif

  // Single-cycle datapath works straight off the request so the result is registered at accept.
  always_comb begin
    sh    = bus.aluB[SHW-1:0];
    res   = '0;
    ovf   = 1'b0;
    unsup = 1'b0;
    isMul = 1'b0;
    case (bus.alufun)
      4'd0: begin
        res = bus.aluA + bus.aluB;
        ovf = (bus.aluA[WIDTH-1] == bus.aluB[WIDTH-1]) && (res[WIDTH-1] != bus.aluA[WIDTH-1]);
      end
      4'd1: begin
        res = bus.aluA - bus.aluB;
        ovf = (bus.aluA[WIDTH-1] != bus.aluB[WIDTH-1]) && (res[WIDTH-1] != bus.aluA[WIDTH-1]);
      end
      4'd2: res = bus.aluA & bus.aluB;
      4'd3: res = bus.aluA ^ bus.aluB;
      4'd4: res = bus.aluA | bus.aluB;
      4'd5: res = bus.aluA << sh;
      4'd6: res = bus.aluA >> sh;
      4'd7: res = $signed(bus.aluA) >>> sh;
`ifdef ALU_MUL_EN
      4'd8: isMul = 1'b1;
`endif
      default: unsup = 1'b1;
    endcase
  end

  always_comb begin
    stateNext = state;
    valENext  = valEReg;
    ccNext    = ccReg;
    errNext   = errReg;
`ifdef ALU_MUL_EN
    cntNext    = cnt;
    accNext    = acc;
    mcandNext  = mcand;
    mplierNext = mplier;
`endif
    case (state)
      IDLE: begin
        if (bus.in_valid) begin
`ifdef ALU_MUL_EN
          if (isMul) begin
            stateNext  = BUSY;
            cntNext    = '0;
            accNext    = '0;
            mcandNext  = bus.aluA;
            mplierNext = bus.aluB;
          end else
`endif
          begin
            // Unsupported ops leave res at zero, which yields cc = 3'b100 naturally.
            stateNext = DONE;
            valENext  = res;
            ccNext    = {res == '0, res[WIDTH-1], ovf};
            errNext   = unsup;
          end
        end
      end
`ifdef ALU_MUL_EN
      BUSY: begin
        if (cnt == CNTW'(WIDTH)) begin
          stateNext = DONE;
          valENext  = acc;
          ccNext    = {acc == '0, acc[WIDTH-1], 1'b0};
          errNext   = 1'b0;
        end else begin
          if (mplier[0]) accNext = acc + mcand;
          mcandNext  = mcand << 1;
          mplierNext = mplier >> 1;
          cntNext    = cnt + CNTW'(1);
        end
      end
`endif
      DONE: begin
        if (bus.out_ready) stateNext = IDLE;
      end
      default: stateNext = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      valEReg <= '0;
      ccReg   <= '0;
      errReg  <= 1'b0;
    end else begin
      state   <= stateNext;
      valEReg <= valENext;
      ccReg   <= ccNext;
      errReg  <= errNext;
    end
  end

`ifdef ALU_MUL_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt    <= '0;
      acc    <= '0;
      mcand  <= '0;
      mplier <= '0;
    end else begin
      cnt    <= cntNext;
      acc    <= accNext;
      mcand  <= mcandNext;
      mplier <= mplierNext;
    end
  end
`endif

  assign bus.in_ready  = (state == IDLE);
  assign bus.out_valid = (state == DONE);
  assign bus.valE      = valEReg;
  assign bus.cc        = ccReg;
  assign bus.err       = errReg;
endmodule
